// File: rtl/snn_pkg.sv
// Shared types, sizes and result formatting for the SNN image loader.
// Optional build macro: SNN_DIGIT_ASCII_EN (transmit the result as ASCII '0'..'9').
package snn_pkg;

  localparam int unsigned NUM_PIXELS = 784;
  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned NUM_BYTES  = NUM_PIXELS / 8;
  localparam int unsigned BYTE_AW    = ADDR_W - 3;
  localparam logic [7:0]  ASCII_ZERO = 8'h30;

  typedef enum logic [2:0] {
    LOAD,
    START,
    RUN,
    SEND,
    WAIT_TX
  } loader_state_t;

  // Converts the core's 4-bit digit into the byte handed to the transmitter.
  function automatic logic [7:0] fmt_result(input logic [3:0] result);
`ifdef SNN_DIGIT_ASCII_EN
    return ASCII_ZERO + {4'h0, result};
`else
    return {4'h0, result};
`endif
  endfunction

endpackage

// File: rtl/snn_input_loader_if.sv
// UART / snn_core / transmitter signal bundle of the image loader.
interface snn_input_loader_if;

  logic                        rx_rdy;
  logic [7:0]                  rx_data;
  logic                        clr_rx_rdy;
  logic                        start;
  logic [snn_pkg::ADDR_W-1:0]  addr_input_unit;
  logic                        q_input;
  logic                        done;
  logic [3:0]                  digit;
  logic                        trmt;
  logic [7:0]                  tx_data;
  logic                        tx_done;
  logic                        busy;

  modport slave (
    input  rx_rdy, rx_data, addr_input_unit, done, digit, tx_done,
    output clr_rx_rdy, start, q_input, trmt, tx_data, busy
  );

  modport master (
    output rx_rdy, rx_data, addr_input_unit, done, digit, tx_done,
    input  clr_rx_rdy, start, q_input, trmt, tx_data, busy
  );

endinterface

// File: rtl/snn_image_ram.sv
// 98x8 image store: byte-wide write, registered single-pixel read.
module snn_image_ram
  import snn_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_we,
  input  logic [BYTE_AW-1:0] i_waddr,
  input  logic [7:0]         i_wdata,
  input  logic [ADDR_W-1:0]  i_raddr,
  output logic               o_q
);

  logic [7:0]         r_mem [NUM_BYTES];
  logic               r_q;
  logic [BYTE_AW-1:0] w_row;
  logic [2:0]         w_bit;
  logic               w_in_range;

  assign w_row      = i_raddr[ADDR_W-1:3];
  assign w_bit      = i_raddr[2:0];
  assign w_in_range = (i_raddr < ADDR_W'(NUM_PIXELS));

  // Image contents are intentionally left unreset.
  always_ff @(posedge i_clk) begin
    if (i_we && (i_waddr < BYTE_AW'(NUM_BYTES))) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= 1'b0;
    end else begin
      r_q <= w_in_range ? r_mem[w_row][w_bit] : 1'b0;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/snn_input_loader.sv
// Loads one 784-pixel image from UART bytes, runs snn_core, returns its digit.
// Optional build macro: SNN_DIGIT_ASCII_EN (see snn_pkg::fmt_result).
module snn_input_loader
  import snn_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  snn_input_loader_if.slave   bus
);

  loader_state_t      r_state, w_state_nxt;
  logic [BYTE_AW-1:0] r_byte_cnt, w_byte_cnt_nxt;
  logic               r_clr_rx_rdy, w_clr_rx_rdy_nxt;
  logic               r_start, w_start_nxt;
  logic               r_trmt, w_trmt_nxt;
  logic               r_busy;
  logic [7:0]         r_tx_data, w_tx_data_nxt;
  logic               w_we;

  snn_image_ram u_ram (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_we    (w_we),
    .i_waddr (r_byte_cnt),
    .i_wdata (bus.rx_data),
    .i_raddr (bus.addr_input_unit),
    .o_q     (bus.q_input)
  );

  // Next state and next registered outputs.
  always_comb begin
    w_state_nxt      = r_state;
    w_byte_cnt_nxt   = r_byte_cnt;
    w_clr_rx_rdy_nxt = 1'b0;
    w_start_nxt      = 1'b0;
    w_trmt_nxt       = 1'b0;
    w_tx_data_nxt    = r_tx_data;
    w_we             = 1'b0;
    case (r_state)
      LOAD: begin
        // Skip the cycle right after a consume so the receiver can drop rx_rdy.
        if (bus.rx_rdy && !r_clr_rx_rdy) begin
          w_we             = 1'b1;
          w_clr_rx_rdy_nxt = 1'b1;
          if (r_byte_cnt == BYTE_AW'(NUM_BYTES - 1)) begin
            w_byte_cnt_nxt = '0;
            w_state_nxt    = START;
          end else begin
            w_byte_cnt_nxt = r_byte_cnt + BYTE_AW'(1);
          end
        end
      end
      START: begin
        w_start_nxt = 1'b1;
        w_state_nxt = RUN;
      end
      RUN: begin
        if (bus.done) begin
          w_tx_data_nxt = fmt_result(bus.digit);
          w_trmt_nxt    = 1'b1;
          w_state_nxt   = SEND;
        end
      end
      SEND: begin
        w_state_nxt = WAIT_TX;
      end
      WAIT_TX: begin
        if (bus.tx_done) begin
          w_state_nxt = LOAD;
        end
      end
      default: begin
        w_state_nxt = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= LOAD;
      r_byte_cnt   <= '0;
      r_clr_rx_rdy <= 1'b0;
      r_start      <= 1'b0;
      r_trmt       <= 1'b0;
      r_busy       <= 1'b0;
      r_tx_data    <= 8'h00;
    end else begin
      r_state      <= w_state_nxt;
      r_byte_cnt   <= w_byte_cnt_nxt;
      r_clr_rx_rdy <= w_clr_rx_rdy_nxt;
      r_start      <= w_start_nxt;
      r_trmt       <= w_trmt_nxt;
      r_busy       <= (w_state_nxt != LOAD);
      r_tx_data    <= w_tx_data_nxt;
    end
  end

  assign bus.clr_rx_rdy = r_clr_rx_rdy;
  assign bus.start      = r_start;
  assign bus.trmt       = r_trmt;
  assign bus.busy       = r_busy;
  assign bus.tx_data    = r_tx_data;

endmodule

// File: tb/tb_snn_input_loader.sv
// Directed self-checking bench for snn_input_loader with a pixel-array reference model.
module tb_snn_input_loader;
  import snn_pkg::*;

`ifdef SNN_DIGIT_ASCII_EN
  localparam logic [7:0] EXP7 = 8'h37;
  localparam logic [7:0] EXP3 = 8'h33;
  localparam logic [7:0] EXP9 = 8'h39;
  localparam logic [7:0] EXP0 = 8'h30;
`else
  localparam logic [7:0] EXP7 = 8'h07;
  localparam logic [7:0] EXP3 = 8'h03;
  localparam logic [7:0] EXP9 = 8'h09;
  localparam logic [7:0] EXP0 = 8'h00;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snn_input_loader_if bus ();

  snn_input_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cnt = 0, clr_cnt = 0, trmt_cnt = 0;
  int last_start_cyc = 0, last_clr_cyc = 0;
  bit q_chk = 1'b0;
  bit model_img [NUM_PIXELS];
  logic [7:0] img [NUM_BYTES];

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse bookkeeping sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.start) begin start_cnt++; last_start_cyc = cyc; end
    if (bus.clr_rx_rdy) begin clr_cnt++; last_clr_cyc = cyc; end
    if (bus.trmt) trmt_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_byte(input int k, input logic [7:0] b);
    for (int i = 0; i < 8; i++) model_img[8*k + i] = b[i];
  endtask

  // q_input for the address seen at an edge must equal the model pixel after that edge.
  initial begin : compare
    logic [ADDR_W-1:0] a;
    bit en;
    bit exp_q;
    forever begin
      @(posedge clk);
      a  = bus.addr_input_unit;
      en = q_chk;
      @(negedge clk);
      if (en) begin
        if (int'(a) < NUM_PIXELS) exp_q = model_img[a];
        else exp_q = 1'b0;
        check("q_model", 32'(bus.q_input), 32'(exp_q));
      end
    end
  end

  // UART receiver: hold the byte until consumed, then drop the flag at the next edge.
  task automatic send_byte(input logic [7:0] b);
    bit seen = 1'b0;
    bus.rx_rdy  = 1'b1;
    bus.rx_data = b;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.clr_rx_rdy) seen = 1'b1;
    end
    if (!seen) check("clr_timeout", 32'(0), 32'(1));
    @(posedge clk);
    #1 bus.rx_rdy = 1'b0;
  endtask

  task automatic load_image(input int first);
    int s0 = start_cnt;
    for (int k = first; k < int'(NUM_BYTES); k++) begin
      send_byte(img[k]);
      model_byte(k, img[k]);
      if (k == 47) check("no_start_at_48", 32'(start_cnt), 32'(s0));
      if (k == int'(NUM_BYTES) - 2) check("no_start_at_97", 32'(start_cnt), 32'(s0));
    end
    repeat (4) @(posedge clk);
    #1;
    check("start_once", 32'(start_cnt), 32'(s0 + 1));
    check("start_latency", 32'(last_start_cyc), 32'(last_clr_cyc + 1));
    check("busy_run", 32'(bus.busy), 32'(1));
  endtask

  task automatic read_lit(input int a, input bit exp_q);
    @(posedge clk);
    #1 bus.addr_input_unit = ADDR_W'(a);
    @(posedge clk);
    @(negedge clk);
    check($sformatf("q_addr_%0d", a), 32'(bus.q_input), 32'(exp_q));
  endtask

  task automatic sweep(input int lo, input int hi, input int step);
    for (int a = lo; a <= hi; a += step) begin
      @(posedge clk);
      #1 bus.addr_input_unit = ADDR_W'(a);
    end
    @(posedge clk);
  endtask

  task automatic finish_run(input logic [3:0] d, input logic [7:0] exp_tx);
    int t0 = trmt_cnt;
    @(posedge clk);
    #1 q_chk = 1'b0; bus.done = 1'b1; bus.digit = d;
    @(posedge clk);
    #1 bus.done = 1'b0;
    @(negedge clk);
    check("trmt_next_cycle", 32'(bus.trmt), 32'(1));
    check("tx_data", 32'(bus.tx_data), 32'(exp_tx));
    @(negedge clk);
    check("trmt_one_cycle", 32'(bus.trmt), 32'(0));
    repeat (3) begin
      @(negedge clk);
      check("tx_data_held", 32'(bus.tx_data), 32'(exp_tx));
      check("busy_wait_tx", 32'(bus.busy), 32'(1));
      check("no_clr_wait_tx", 32'(bus.clr_rx_rdy), 32'(0));
    end
    check("trmt_count", 32'(trmt_cnt), 32'(t0 + 1));
  endtask

  task automatic tx_done_pulse();
    @(posedge clk);
    #1 bus.tx_done = 1'b1;
    @(posedge clk);
    #1 bus.tx_done = 1'b0;
    @(negedge clk);
    check("busy_drop", 32'(bus.busy), 32'(0));
  endtask

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int s, t, c;
    bus.rx_rdy = 1'b0; bus.rx_data = 8'h00; bus.addr_input_unit = '0;
    bus.done = 1'b0; bus.digit = 4'h0; bus.tx_done = 1'b0;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_clr", 32'(bus.clr_rx_rdy), 32'(0));
    check("rst_start", 32'(bus.start), 32'(0));
    check("rst_trmt", 32'(bus.trmt), 32'(0));
    check("rst_q", 32'(bus.q_input), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_tx_data", 32'(bus.tx_data), 32'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;

    // All-ones image.
    for (int k = 0; k < int'(NUM_BYTES); k++) img[k] = 8'hFF;
    load_image(0);
    q_chk = 1'b1;
    read_lit(0, 1'b1);
    read_lit(400, 1'b1);
    read_lit(783, 1'b1);
    read_lit(784, 1'b0);
    read_lit(1023, 1'b0);
    sweep(770, 790, 1);

    // tx_done during RUN is ignored.
    s = start_cnt; t = trmt_cnt;
    @(posedge clk);
    #1 bus.tx_done = 1'b1;
    @(posedge clk);
    #1 bus.tx_done = 1'b0;
    repeat (2) @(negedge clk);
    check("run_ignores_tx_done_busy", 32'(bus.busy), 32'(1));
    check("run_ignores_tx_done_trmt", 32'(trmt_cnt), 32'(t));
    check("run_ignores_tx_done_start", 32'(start_cnt), 32'(s));

    // Byte pending through RUN / SEND / WAIT_TX is consumed on the first LOAD cycle.
    @(posedge clk);
    #1 bus.rx_rdy = 1'b1; bus.rx_data = 8'h01;
    c = clr_cnt;
    finish_run(4'd7, EXP7);
    check("no_clr_while_busy", 32'(clr_cnt), 32'(c));
    @(posedge clk);
    #1 bus.tx_done = 1'b1;
    @(posedge clk);
    #1 bus.tx_done = 1'b0;
    @(negedge clk);
    check("busy_after_tx_done", 32'(bus.busy), 32'(0));
    check("clr_not_yet", 32'(bus.clr_rx_rdy), 32'(0));
    @(negedge clk);
    check("clr_first_load", 32'(bus.clr_rx_rdy), 32'(1));
    @(posedge clk);
    #1 bus.rx_rdy = 1'b0;
    check("pending_consumed_once", 32'(clr_cnt), 32'(c + 1));

    // Rest of the 0x01 image, continuing from byte 1.
    for (int k = 0; k < int'(NUM_BYTES); k++) img[k] = 8'h01;
    model_byte(0, 8'h01);
    load_image(1);
    q_chk = 1'b1;
    read_lit(0, 1'b1);
    read_lit(1, 1'b0);
    read_lit(8, 1'b1);
    read_lit(783, 1'b0);
    sweep(0, 40, 1);
    finish_run(4'd3, EXP3);
    tx_done_pulse();

    // Reload with the last byte 0x80.
    img[NUM_BYTES-1] = 8'h80;
    load_image(0);
    q_chk = 1'b1;
    read_lit(783, 1'b1);
    read_lit(776, 1'b0);
    read_lit(775, 1'b0);
    read_lit(784, 1'b0);
    finish_run(4'd9, EXP9);
    tx_done_pulse();

    // done and tx_done while in LOAD are ignored.
    s = start_cnt; t = trmt_cnt;
    @(posedge clk);
    #1 bus.done = 1'b1; bus.digit = 4'd5;
    @(posedge clk);
    #1 bus.done = 1'b0; bus.tx_done = 1'b1;
    @(posedge clk);
    #1 bus.tx_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("load_ignores_done_busy", 32'(bus.busy), 32'(0));
      check("load_ignores_done_trmt", 32'(bus.trmt), 32'(0));
    end
    check("load_ignores_done_tcnt", 32'(trmt_cnt), 32'(t));
    check("load_ignores_done_scnt", 32'(start_cnt), 32'(s));
    check("tx_data_kept", 32'(bus.tx_data), 32'(EXP9));

    // Reset after 50 bytes discards the partial image.
    for (int k = 0; k < 50; k++) begin
      send_byte(8'(k * 37 + 5));
      model_byte(k, 8'(k * 37 + 5));
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(bus.busy), 32'(0));
    check("midrst_tx_data", 32'(bus.tx_data), 32'(0));
    check("midrst_q", 32'(bus.q_input), 32'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < int'(NUM_BYTES); k++) img[k] = 8'(k * 53 + 11) ^ 8'hA5;
    load_image(0);
    q_chk = 1'b1;
    sweep(0, 799, 7);
    read_lit(783, model_img[783]);
    finish_run(4'd0, EXP0);
    tx_done_pulse();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
